// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath.
// Holds the transform size, the bit-reversal helper used by the input
// and output reordering stages, and the output serializer state encoding.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;

  // Serializer FSM encoding; plain constants keep it legacy-tool friendly.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Mirror a 4-bit index: bit 0 <-> bit 3, bit 1 <-> bit 2.
  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_out_serializer.sv
// Parallel-to-serial output stage of the 16-point FFT.
// A one-cycle SEL captures all 16 complex results into a register bank;
// the bank is then streamed one word per accepted handshake, in natural
// frequency order (BITREV=1) or in raw bank order (BITREV=0).
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RESET      asynchronous active-low reset
//   SEL        one-cycle load strobe from the controller
//   PAR_RE/IM  16 packed components, bank i at [i*W +: W]
//   OUT_RE/IM  current output word
//   OUT_IDX    natural-order frequency index k of the current word
//   OUT_VALID  word presented
//   OUT_READY  downstream accepts the word
//   OUT_LAST   presented word is k==15
//   BUSY       a frame is held and not yet drained
//   OVERRUN    sticky: a SEL arrived while a frame was still draining
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int W      = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SEL,
  input  logic [FFT_N*W-1:0]   PAR_RE,
  input  logic [FFT_N*W-1:0]   PAR_IM,
  output logic [W-1:0]         OUT_RE,
  output logic [W-1:0]         OUT_IM,
  output logic [FFT_LOG2N-1:0] OUT_IDX,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_LAST,
  output logic                 BUSY,
  output logic                 OVERRUN
);

  localparam logic [FFT_LOG2N-1:0] K_LAST = FFT_LOG2N'(FFT_N - 1);

  logic [0:0]           r_state;
  logic [FFT_LOG2N-1:0] r_k;
  logic                 r_overrun;
  logic [W-1:0]         r_bank_re [FFT_N];
  logic [W-1:0]         r_bank_im [FFT_N];

  logic                 w_stream;
  logic                 w_accept;
  logic                 w_final;
  logic                 w_load;
  logic [FFT_LOG2N-1:0] w_rd_idx;

  assign w_stream = (r_state == ST_STREAM);
  assign w_accept = w_stream & OUT_READY;
  assign w_final  = w_accept & (r_k == K_LAST);
  // A load is taken from IDLE, or on the very edge that drains the last
  // word, which lets frames run back to back without a bubble.
  assign w_load   = SEL & (~w_stream | w_final);

  // NOTE: the bank is reset because the idle outputs must read as zero out of
  // reset; a bank without reset would be cheaper but would show X on OUT_RE/IM.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FFT_N; i++) begin
        r_bank_re[i] <= '0;
        r_bank_im[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < FFT_N; i++) begin
        r_bank_re[i] <= PAR_RE[i*W +: W];
        r_bank_im[i] <= PAR_IM[i*W +: W];
      end
      r_k     <= '0;
      r_state <= ST_STREAM;
    end else begin
      // SEL without a load can only happen mid-frame: the strobe is dropped.
      if (SEL) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_k <= r_k + 1'b1;
        if (w_final) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  // Read mux is driven from registered state only; OUT_READY and SEL never
  // reach an output combinationally.
  assign w_rd_idx  = BITREV ? bitrev4(r_k) : r_k;
  assign OUT_RE    = r_bank_re[w_rd_idx];
  assign OUT_IM    = r_bank_im[w_rd_idx];
  assign OUT_IDX   = r_k;
  assign OUT_VALID = w_stream;
  assign BUSY      = w_stream;
  assign OUT_LAST  = w_stream & (r_k == K_LAST);
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed testbench for fft_out_serializer.
// Two instances share stimulus: one in natural order (BITREV=1), one in
// bank order (BITREV=0). Inputs change on the falling edge and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_fft_out_serializer;

  localparam int W = 16;
  localparam int N = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           SEL;
  logic [N*W-1:0] PAR_RE;
  logic [N*W-1:0] PAR_IM;
  logic           OUT_READY;

  logic [W-1:0] OUT_RE, OUT_IM;
  logic [3:0]   OUT_IDX;
  logic         OUT_VALID, OUT_LAST, BUSY, OVERRUN;

  logic [W-1:0] b0_re, b0_im;
  logic [3:0]   b0_idx;
  logic         b0_valid, b0_last, b0_busy, b0_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  fft_out_serializer #(.W(W), .BITREV(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .SEL(SEL), .PAR_RE(PAR_RE), .PAR_IM(PAR_IM),
    .OUT_RE(OUT_RE), .OUT_IM(OUT_IM), .OUT_IDX(OUT_IDX), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  fft_out_serializer #(.W(W), .BITREV(1'b0)) dut_bank (
    .CLK(CLK), .RESET(RESET), .SEL(SEL), .PAR_RE(PAR_RE), .PAR_IM(PAR_IM),
    .OUT_RE(b0_re), .OUT_IM(b0_im), .OUT_IDX(b0_idx), .OUT_VALID(b0_valid),
    .OUT_READY(OUT_READY), .OUT_LAST(b0_last), .BUSY(b0_busy), .OVERRUN(b0_overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Bit reversal written as a loop over bit positions.
  function automatic logic [3:0] rev(input int k);
    logic [3:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if ((k >> b) & 1) r[3-b] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] ere(input int base, input int bank);
    return W'(base + bank);
  endfunction

  function automatic logic [W-1:0] eim(input int base, input int bank);
    return W'(-(base + bank));
  endfunction

  task automatic set_par(input int base);
    for (int i = 0; i < N; i++) begin
      PAR_RE[i*W +: W] = ere(base, i);
      PAR_IM[i*W +: W] = eim(base, i);
    end
  endtask

  // Pulse SEL for one edge; returns on the falling edge after the load.
  task automatic load_frame(input int base);
    set_par(base);
    SEL = 1'b1;
    @(negedge CLK);
    SEL = 1'b0;
  endtask

  initial begin
    int ek;
    int acc;
    bit done;

    RESET = 1'b0; SEL = 1'b0; OUT_READY = 1'b1; PAR_RE = '0; PAR_IM = '0;

    // Reset state
    #12;
    check("rst_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_last", OUT_LAST, 0);
    check("rst_overrun", OVERRUN, 0);
    check("rst_re", OUT_RE, 0);
    check("rst_im", OUT_IM, 0);
    check("rst_idx", OUT_IDX, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("idle_valid", OUT_VALID, 0);

    // Natural-order frame, plus bank-order instance on the same data
    load_frame(0);
    for (int k = 0; k < N; k++) begin
      check("nat_valid", OUT_VALID, 1);
      check("nat_busy", BUSY, 1);
      check("nat_idx", OUT_IDX, k);
      check("nat_re", OUT_RE, ere(0, rev(k)));
      check("nat_im", OUT_IM, eim(0, rev(k)));
      check("nat_last", OUT_LAST, (k == N-1));
      check("bank_re", b0_re, ere(0, k));
      check("bank_idx", b0_idx, k);
      @(negedge CLK);
    end
    check("nat_end_valid", OUT_VALID, 0);
    check("nat_end_busy", BUSY, 0);
    check("nat_end_last", OUT_LAST, 0);
    check("bank_end_valid", b0_valid, 0);

    // Backpressure: READY pattern 1,0,0,1 repeating
    load_frame(32);
    ek = 0; acc = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      check("bp_valid", OUT_VALID, 1);
      check("bp_idx", OUT_IDX, ek);
      check("bp_re", OUT_RE, ere(32, rev(ek)));
      check("bp_im", OUT_IM, eim(32, rev(ek)));
      check("bp_last", OUT_LAST, (ek == N-1));
      OUT_READY = ((c % 4) == 0) || ((c % 4) == 3);
      if (OUT_READY) begin
        acc++;
        if (ek == N-1) done = 1'b1;
        ek++;
      end
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    check("bp_done", done, 1);
    check("bp_accepts", acc, 16);
    check("bp_end_valid", OUT_VALID, 0);

    // Back-to-back: new SEL on the final accept edge
    load_frame(0);
    for (int k = 0; k < N; k++) begin
      check("b2b_a_idx", OUT_IDX, k);
      check("b2b_a_re", OUT_RE, ere(0, rev(k)));
      if (k == N-1) begin
        set_par(256);
        SEL = 1'b1;
      end
      @(negedge CLK);
      SEL = 1'b0;
    end
    check("b2b_valid", OUT_VALID, 1);
    check("b2b_overrun", OVERRUN, 0);
    for (int k = 0; k < N; k++) begin
      check("b2b_b_idx", OUT_IDX, k);
      check("b2b_b_re", OUT_RE, ere(256, rev(k)));
      check("b2b_b_im", OUT_IM, eim(256, rev(k)));
      @(negedge CLK);
    end
    check("b2b_end_valid", OUT_VALID, 0);
    check("b2b_end_overrun", OVERRUN, 0);

    // Overrun: SEL at k=5 with different data is dropped
    load_frame(0);
    for (int k = 0; k < N; k++) begin
      check("ovr_idx", OUT_IDX, k);
      check("ovr_re", OUT_RE, ere(0, rev(k)));
      check("ovr_flag", OVERRUN, (k > 5));
      if (k == 5) begin
        set_par(512);
        SEL = 1'b1;
      end
      @(negedge CLK);
      SEL = 1'b0;
    end
    check("ovr_end_valid", OUT_VALID, 0);
    load_frame(64);
    check("ovr_next_idx", OUT_IDX, 0);
    check("ovr_next_re", OUT_RE, ere(64, 0));
    check("ovr_sticky", OVERRUN, 1);
    repeat (16) @(negedge CLK);
    check("ovr_next_end", OUT_VALID, 0);
    check("ovr_sticky2", OVERRUN, 1);

    // Reset asserted between edges at k=7
    load_frame(80);
    repeat (7) @(negedge CLK);
    check("rmid_idx", OUT_IDX, 7);
    #2 RESET = 1'b0;
    #1;
    check("rmid_valid", OUT_VALID, 0);
    check("rmid_busy", BUSY, 0);
    check("rmid_overrun", OVERRUN, 0);
    check("rmid_last", OUT_LAST, 0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rmid_idle", OUT_VALID, 0);
    end
    load_frame(96);
    check("rmid_new_valid", OUT_VALID, 1);
    check("rmid_new_idx", OUT_IDX, 0);
    check("rmid_new_re", OUT_RE, ere(96, 0));
    check("rmid_new_im", OUT_IM, eim(96, 0));
    repeat (16) @(negedge CLK);
    check("rmid_new_end", OUT_VALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Parallel-to-serial output stage of the 16-point FFT. On the controller's one-cycle `SEL` pulse it captures all 16 complex results from the butterfly array in one cycle. It then streams them one per cycle over a valid/ready handshake, optionally reordering from bit-reversed to natural order. With `OUT_READY` held high, the first word appears in the same cycle the controller raises `DONE`.

## Interface
- Reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - `W`, default 16: bit width of each real or imaginary component (two's complement).
  - `BITREV`, default 1: 1 = emit in natural order (read bank index `bitrev4(k)`); 0 = emit in bank order.
- Ports:
  - `CLK` in 1: clock, all state on its rising edge.
  - `RESET` in 1: asynchronous, active-low reset.
  - `SEL` in 1: load strobe from the controller, one cycle wide.
  - `PAR_RE` in 16*W: real parts; bank index i occupies bits [i*W +: W].
  - `PAR_IM` in 16*W: imaginary parts, same packing as `PAR_RE`.
  - `OUT_RE` out W: current real output word.
  - `OUT_IM` out W: current imaginary output word.
  - `OUT_IDX` out 4: natural-order frequency index k of the current word.
  - `OUT_VALID` out 1: a word is presented.
  - `OUT_READY` in 1: downstream accepts the word.
  - `OUT_LAST` out 1: high together with `OUT_VALID` when `OUT_IDX`==15.
  - `BUSY` out 1: a frame is held and not yet fully drained.
  - `OVERRUN` out 1: sticky; a `SEL` was dropped.

## Operation
- State machine has two states, IDLE and STREAM.
- **IDLE:**
  - `OUT_VALID`=0 and `BUSY`=0.
  - When `SEL`=1: capture all 32 components into the bank, clear counter k to 0, go to STREAM.
- **STREAM:**
  - `OUT_VALID`=1 and `BUSY`=1.
  - Output word is bank[`BITREV` ? bitrev4(k) : k]; `OUT_IDX`=k.
  - A word is accepted on any edge where `OUT_VALID`&`OUT_READY`; the counter then advances k→k+1.
  - On acceptance with k==15, go to IDLE.
  - With `OUT_READY`=0, `OUT_RE`, `OUT_IM`, `OUT_IDX` and `OUT_LAST` hold stable.
- **Data path:** no arithmetic. Values pass through bit-exact.
- **Boundary conditions:**
  - **`SEL` while in STREAM, not a final accept:** ignore the load. The bank is not modified. Set `OVERRUN`=1. The current frame continues unchanged.
  - **`SEL` on the same edge as the final accept (k==15):** accept the last word, load the new frame, k=0, stay in STREAM. `OVERRUN` is unchanged. This allows back-to-back frames with no gap.
  - **`SEL` held high for multiple cycles:**
    - The first cycle loads.
    - Each later cycle in STREAM counts as an overrun, except a cycle that coincides with the final accept.
  - **`OVERRUN` clearing:** cleared only by reset.
  - **Reset asserted mid-frame:** immediate return to IDLE and the frame is discarded. After reset is released, output stays idle until the next `SEL`.

## Timing
- **Reset values:**
  - `OUT_VALID`, `OUT_LAST`, `BUSY` and `OVERRUN` = 0.
  - `OUT_RE`, `OUT_IM` and `OUT_IDX` = 0.
  - Bank contents = 0.
- **Load latency:** `SEL` sampled high at edge t → `OUT_VALID`=1 and word k=0 visible in the cycle following t. This matches the controller's `DONE` cycle.
- **Throughput:** one word per cycle when `OUT_READY`=1. A frame drains in 16 cycles.
- **Timing against the controller:** with `OUT_READY`=1 the frame occupies controller states 18..33; `OUT_LAST` is in state 33.
- **Output paths:** all outputs are registered or driven straight from state. There is no combinational path from `OUT_READY` or `SEL` to any output.

## Structure
- **Shared package `fft_pkg`:**
  - `FFT_N`=16 and `FFT_LOG2N`=4.
  - Function `bitrev4`.
  - The state encoding: IDLE, STREAM.
  - The controller and the input serial-to-parallel stage reuse `FFT_N` and `bitrev4`.
- **Sub-modules:** none needed. The bank is 32 W-bit registers plus one 16:1 read mux. Both stay inline.

## Test plan
- **Natural-order frame:**
  - Stimulus: bank i holds re=i, im=-i; `BITREV`=1; `OUT_READY`=1; one `SEL` pulse.
  - Required response: 16 consecutive words, word k has re=bitrev4(k) and `OUT_IDX`=k, `OUT_LAST` on k=15 only, then `OUT_VALID`=0.
- **Backpressure:**
  - Stimulus: toggle `OUT_READY` 1,0,0,1,… during a frame.
  - Required response: no word lost or duplicated; outputs stable while stalled; frame ends only after 16 accepts.
- **Back-to-back frames:**
  - Stimulus: second `SEL` on the edge of the final accept, carrying new data 0x100+i.
  - Required response: the next cycle shows the new frame with k=0; `OVERRUN` stays 0.
- **Overrun:**
  - Stimulus: `SEL` at k=5 with different data.
  - Required response: the remaining words k=5..15 come from the original frame; `OVERRUN`=1 and stays 1 through later frames.
- **Reset mid-frame:**
  - Stimulus: assert `RESET` low asynchronously at k=7 (between edges).
  - Required response: `OUT_VALID`, `BUSY` and `OVERRUN` go to 0 immediately; no output until a fresh `SEL` produces a frame starting at k=0.
- **`BITREV`=0 build:**
  - Stimulus: same frame as the natural-order test.
  - Required response: word k has re=k.
